kcpsm3_int_ctrl: RTL and testbench
==================================

# kcpsm3_int_ctrl

Four-source interrupt controller sitting directly upstream of the KCPSM3 `interrupt` input. It synchronises four asynchronous request lines, captures rising edges into a pending register, OR-reduces pending-and-enabled sources into a single registered interrupt request, and hands the processor a source index on acknowledge. The processor programs it and reads it through the standard KCPSM3 port bus.

## Interface
Parameters:
- `BASE_PORT`, 8'h40: base port address; the block decodes `BASE_PORT+0..2`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_in`  in  4  asynchronous request lines; a rising edge requests service.
- `port_id`  in  8  KCPSM3 port address.
- `write_strobe`  in  1  KCPSM3 OUTPUT strobe.
- `read_strobe`  in  1  KCPSM3 INPUT strobe; the block does not use it for reads, which are side-effect free.
- `out_port`  in  8  KCPSM3 write data.
- `in_port`  out  8  registered read data to the KCPSM3.
- `interrupt`  out  1  registered interrupt request to the KCPSM3.
- `interrupt_ack`  in  1  KCPSM3 acknowledge, a one-cycle pulse.

## Operation
Registers, with offsets from `BASE_PORT`:
- +0 MASK: read/write; bits 3:0 enable sources; bits 7:4 read as 0.
- +1 PEND: read returns the 4 pending bits. A write clears each bit written as 1 (write-1-to-clear).
- +2 SRC: read-only. Bit 7 = valid, bits 1:0 = index of the last acknowledged source, other bits 0.

Request path:
- Each `irq_in` bit passes through a 2-flop synchroniser, then a third flop for edge detection.
- edge = s2 & ~s3. An edge sets the PEND bit.
- Levels are ignored: a source held high raises only one request.

Interrupt generation:
- `interrupt` is registered as OR(PEND & MASK) and is held until acknowledged.
- On `interrupt_ack`:
  - SRC loads {valid=1, lowest-index set bit of PEND & MASK}.
  - That PEND bit clears.
  - `interrupt` drops to 0 on the same clock edge.
- On the next edge, `interrupt` re-evaluates from the updated PEND & MASK.
- If `interrupt_ack` arrives while PEND & MASK = 0, SRC valid is written to 0 and PEND is unchanged.

Priority and conflicts:
- Priority is fixed; bit 0 is highest.
- Edge-set and clear of the same PEND bit in the same cycle (W1C write or ack): set wins.
- Masking a pending source does not clear it. It re-asserts `interrupt` when unmasked.

Read path:
- `in_port` is registered each cycle from a mux on `port_id`.
- Unmapped addresses return 8'h00.

Reset values:
- MASK = 0, PEND = 0, SRC = 8'h00.
- `interrupt` = 0, `in_port` = 8'h00.
- All synchroniser and edge flops = 0.
- Reset mid-request discards all pending state. No spurious edge follows reset while `irq_in` is held high, because s3 tracks s2.

## Timing
- `irq_in[i]` first sampled high at edge k: PEND[i] set at edge k+2, `interrupt` high at edge k+3 (if MASK[i]=1).
- A MASK write at edge w takes effect on `interrupt` at edge w+1.
- Ack at edge a: SRC and PEND update at a. `interrupt` is 0 after a and may re-assert at a+1.
- Read latency is 1 cycle from `port_id`. This fits within the 2-cycle KCPSM3 INPUT instruction.
- Minimum `irq_in` pulse width is 2 `clk` periods for guaranteed capture.

## Structure
- Package `kcpsm3_int_pkg`:
  - `NUM_SRC` = 4.
  - Register offsets `OFS_MASK` = 0, `OFS_PEND` = 1, `OFS_SRC` = 2.
  - SRC field positions.
- Sub-module `int_edge_sync`: one-bit 2-flop synchroniser plus edge flop, with `clk`/`reset` and a pulse output. It is instantiated 4 times.
- Top level holds MASK/PEND/SRC, the priority encoder, the OR-reduce, and the read mux.

## Test plan
- Reset: hold `reset` for 2 cycles with `irq_in`=4'hF. Required: all outputs 0, and no PEND bit ever sets while `irq_in` stays high.
- Single source: MASK=4'h4, pulse `irq_in[2]` for 2 cycles. Required:
  - PEND=4'h4, then `interrupt`=1 exactly 3 edges after first sample.
  - Ack: SRC=8'h82, PEND=0, `interrupt`=0.
- Priority: MASK=4'hF, edges on bits 3 and 1 together. Required:
  - First ack: SRC=8'h81, and `interrupt` re-asserts the next cycle.
  - Second ack: SRC=8'h83.
- Masking: MASK=0, edge on bit 0. Required: PEND=4'h1 and `interrupt` stays 0. Write MASK=4'h1: `interrupt`=1 one cycle later.
- Set/clear collision: write PEND=4'h1 (W1C) in the same cycle as a new bit-0 edge. Required: PEND[0] remains 1.
- Read bus: read BASE_PORT+3 → 8'h00; read MASK after writing 8'hFF → 8'h0F.

Source files
------------

// File: rtl/kcpsm3_int_pkg.sv
// ============================================================================
// kcpsm3_int_pkg : shared constants and priority helper for kcpsm3_int_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package kcpsm3_int_pkg;

  localparam int NUM_SRC = 4;
  localparam int IDX_W   = 2;

  localparam logic [7:0] OFS_MASK = 8'd0;
  localparam logic [7:0] OFS_PEND = 8'd1;
  localparam logic [7:0] OFS_SRC  = 8'd2;

  localparam int SRC_VALID_BIT = 7;
  localparam int SRC_IDX_LSB   = 0;

  // Fixed priority: lowest set bit wins. Returns 0 when nothing is set.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [NUM_SRC-1:0] req);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kcpsm3_int_ctrl_int_edge_sync.sv
// ============================================================================
// int_edge_sync : 2-flop synchroniser plus edge flop, one-cycle rising pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module int_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q;
  logic arm1_q, arm2_q;

  // Until the pipe has refilled after reset, s3 is loaded alongside s2 so a
  // line already high at reset release is seen as a level, not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      arm1_q <= 1'b0;
      arm2_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= arm2_q ? s2_q : s1_q;
      arm1_q <= 1'b1;
      arm2_q <= arm1_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

`default_nettype wire

// File: rtl/kcpsm3_int_ctrl.sv
// ============================================================================
// kcpsm3_int_ctrl : four-source edge-captured interrupt controller on the
//                   KCPSM3 port bus (MASK / PEND W1C / SRC registers)
// Rev 1.0
// ============================================================================
`default_nettype none

module kcpsm3_int_ctrl
  import kcpsm3_int_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = 8'h40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic [7:0]         out_port,
  output logic [7:0]         in_port,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  localparam logic [7:0] ADDR_MASK = BASE_PORT + OFS_MASK;
  localparam logic [7:0] ADDR_PEND = BASE_PORT + OFS_PEND;
  localparam logic [7:0] ADDR_SRC  = BASE_PORT + OFS_SRC;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic               src_valid_q, src_valid_d;
  logic [IDX_W-1:0]   src_idx_q, src_idx_d;
  logic               irq_q, irq_d;
  logic [7:0]         in_port_q, in_port_d;

  logic [NUM_SRC-1:0] w_active;
  logic [IDX_W-1:0]   w_win;
  logic               w_wr_mask, w_wr_pend;
  logic [7:0]         w_src_byte;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    int_edge_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (irq_in[i]),
      .pulse_o (w_edge[i])
    );
  end

  // Reads have no side effects, so the read strobe and upper data bits are spare.
  logic unused_ok;
  assign unused_ok = ^{read_strobe, out_port[7:NUM_SRC]};

  assign w_active  = pend_q & mask_q;
  assign w_win     = prio_idx(w_active);
  assign w_wr_mask = write_strobe && (port_id == ADDR_MASK);
  assign w_wr_pend = write_strobe && (port_id == ADDR_PEND);

  always_comb begin
    mask_d      = mask_q;
    pend_d      = pend_q;
    src_valid_d = src_valid_q;
    src_idx_d   = src_idx_q;
    irq_d       = irq_q | (|w_active);

    if (w_wr_mask) mask_d = out_port[NUM_SRC-1:0];
    if (w_wr_pend) pend_d = pend_d & ~out_port[NUM_SRC-1:0];

    if (interrupt_ack) begin
      irq_d       = 1'b0;
      src_valid_d = |w_active;
      if (|w_active) begin
        src_idx_d         = w_win;
        pend_d[w_win]     = 1'b0;
      end
    end

    // New edges are applied last so a same-cycle clear never loses them.
    pend_d = pend_d | w_edge;
  end

  always_comb begin
    w_src_byte                            = 8'h00;
    w_src_byte[SRC_VALID_BIT]             = src_valid_q;
    w_src_byte[SRC_IDX_LSB +: IDX_W]      = src_idx_q;

    in_port_d = 8'h00;
    case (port_id)
      ADDR_MASK: in_port_d = {{(8-NUM_SRC){1'b0}}, mask_q};
      ADDR_PEND: in_port_d = {{(8-NUM_SRC){1'b0}}, pend_q};
      ADDR_SRC:  in_port_d = w_src_byte;
      default:   in_port_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q      <= '0;
      pend_q      <= '0;
      src_valid_q <= 1'b0;
      src_idx_q   <= '0;
      irq_q       <= 1'b0;
      in_port_q   <= 8'h00;
    end else begin
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      src_valid_q <= src_valid_d;
      src_idx_q   <= src_idx_d;
      irq_q       <= irq_d;
      in_port_q   <= in_port_d;
    end
  end

  assign in_port   = in_port_q;
  assign interrupt = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_kcpsm3_int_ctrl.sv
// ============================================================================
// tb_kcpsm3_int_ctrl : directed scoreboard bench for kcpsm3_int_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_kcpsm3_int_ctrl;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  kcpsm3_int_ctrl #(.BASE_PORT(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_in        (irq_in),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    push(tag, {7'd0, exp});
    pop_check({7'd0, interrupt});
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    port_id     = addr;
    read_strobe = 1'b1;
    push(tag, exp);
    tick();
    read_strobe = 1'b0;
    pop_check(in_port);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; irq_in = 4'hF; port_id = 8'h00; write_strobe = 1'b0;
    read_strobe = 1'b0; out_port = 8'h00; interrupt_ack = 1'b0;
    tick(); tick();
    chk_irq("reset_irq", 1'b0);
    push("reset_in_port", 8'h00); pop_check(in_port);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rd("reset_no_pend", BASE + 8'd1, 8'h00);
    chk_irq("reset_no_irq", 1'b0);
    irq_in = 4'h0;
    for (int i = 0; i < 4; i++) tick();
    rd("quiet_pend", BASE + 8'd1, 8'h00);

    // Single source: bit 2, two-cycle pulse
    wr(BASE, 8'h04);
    irq_in = 4'h4;
    tick();                      // edge k
    tick();                      // k+1
    irq_in = 4'h0;
    tick();                      // k+2: PEND set
    chk_irq("single_irq_k2", 1'b0);
    tick();                      // k+3
    chk_irq("single_irq_k3", 1'b1);
    rd("single_pend", BASE + 8'd1, 8'h04);
    ack();
    chk_irq("single_irq_after_ack", 1'b0);
    rd("single_src", BASE + 8'd2, 8'h82);
    rd("single_pend_clr", BASE + 8'd1, 8'h00);

    // Priority: bits 3 and 1 together
    wr(BASE, 8'h0F);
    irq_in = 4'hA;
    tick(); tick();
    irq_in = 4'h0;
    tick(); tick();
    chk_irq("prio_irq", 1'b1);
    ack();
    chk_irq("prio_ack1_drop", 1'b0);
    tick();
    chk_irq("prio_reassert", 1'b1);
    rd("prio_src1", BASE + 8'd2, 8'h81);
    ack();
    chk_irq("prio_ack2_drop", 1'b0);
    rd("prio_src2", BASE + 8'd2, 8'h83);
    chk_irq("prio_idle", 1'b0);

    // Ack with nothing pending: valid clears, PEND untouched
    ack();
    rd("empty_ack_valid", BASE + 8'd2, 8'h03);
    rd("empty_ack_pend", BASE + 8'd1, 8'h00);

    // Masking
    wr(BASE, 8'h00);
    irq_in = 4'h1;
    tick(); tick();
    irq_in = 4'h0;
    tick(); tick(); tick();
    chk_irq("masked_irq", 1'b0);
    rd("masked_pend", BASE + 8'd1, 8'h01);
    wr(BASE, 8'h01);
    chk_irq("unmask_w", 1'b0);
    tick();
    chk_irq("unmask_w1", 1'b1);
    ack();
    rd("unmask_src", BASE + 8'd2, 8'h80);
    rd("unmask_pend_clr", BASE + 8'd1, 8'h00);

    // Set/clear collision: W1C lands on the same edge the bit-0 edge sets PEND
    wr(BASE, 8'h00);
    irq_in = 4'h1;
    tick();                      // k
    tick();                      // k+1
    irq_in = 4'h0;
    wr(BASE + 8'd1, 8'h01);      // k+2
    rd("collide_pend", BASE + 8'd1, 8'h01);
    wr(BASE + 8'd1, 8'h01);
    rd("w1c_pend", BASE + 8'd1, 8'h00);

    // Read bus
    rd("unmapped", BASE + 8'd3, 8'h00);
    wr(BASE, 8'hFF);
    rd("mask_readback", BASE, 8'h0F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
